// File: rtl/pwm_capture.sv
// PWM period / high-time capture with a two-flop input synchroniser.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to reject high or low pulses shorter than 3 synchronised samples.
module pwm_capture #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  pwm_in,
    output logic [WORD_WIDTH-1:0] period,
    output logic [WORD_WIDTH-1:0] high_time,
    output logic                  valid,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic                  s, sd_q;
    logic                  rise, fall, cntMax;
    logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
    logic [WORD_WIDTH-1:0] highLatch_q, highLatch_d;
    logic [WORD_WIDTH-1:0] period_q, period_d;
    logic [WORD_WIDTH-1:0] highTime_q, highTime_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sd_q    <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sd_q    <= s;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // s only follows the synchroniser once three consecutive samples agree,
    // so both edges are delayed by the same two cycles.
    logic hist1_q, hist2_q, filt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist1_q <= 1'b0;
            hist2_q <= 1'b0;
            filt_q  <= 1'b0;
        end else begin
            hist1_q <= sync2_q;
            hist2_q <= hist1_q;
            filt_q  <= s;
        end
    end

    assign s = ((sync2_q == hist1_q) && (hist1_q == hist2_q)) ? sync2_q : filt_q;
`else
    assign s = sync2_q;
`endif

    assign rise   = s & ~sd_q;
    assign fall   = ~s & sd_q;
    assign cntMax = &cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            highLatch_q <= '0;
            period_q    <= '0;
            highTime_q  <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            highLatch_q <= highLatch_d;
            period_q    <= period_d;
            highTime_q  <= highTime_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
        end
    end

    // Saturation wins over an edge in the same cycle: the measurement is already invalid.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        highLatch_d = highLatch_q;
        period_d    = period_q;
        highTime_d  = highTime_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;

        if (clear) begin
            state_d     = IDLE;
            cnt_d       = '0;
            highLatch_d = '0;
            period_d    = '0;
            highTime_d  = '0;
            overflow_d  = 1'b0;
        end else if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = WORD_WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (cntMax) begin
                        state_d    = IDLE;
                        overflow_d = 1'b1;
                    end else if (fall) begin
                        state_d     = LOW;
                        highLatch_d = cnt_q;
                        cnt_d       = cnt_q + WORD_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + WORD_WIDTH'(1);
                    end
                end
                LOW: begin
                    if (cntMax) begin
                        state_d    = IDLE;
                        overflow_d = 1'b1;
                    end else if (rise) begin
                        state_d    = HIGH;
                        period_d   = cnt_q;
                        highTime_d = highLatch_q;
                        valid_d    = 1'b1;
                        cnt_d      = WORD_WIDTH'(1);
                    end else begin
                        cnt_d = cnt_q + WORD_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign period    = period_q;
    assign high_time = highTime_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a 32-bit instance for the main scenarios and a 4-bit one for saturation.
module tb_pwm_capture;

    typedef struct {
        logic [31:0] p;
        logic [31:0] h;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic        pwmA;
    logic        pwmB;
    logic [31:0] periodA, highA;
    logic        validA, overflowA;
    logic [3:0]  periodB, highB;
    logic        validB, overflowB;

    exp_t qA[$];
    exp_t qB[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    bit   prevValidA  = 1'b0;
    bit   prevValidB  = 1'b0;

    pwm_capture #(.WORD_WIDTH(32)) dutA (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .clear     (clear),
        .pwm_in    (pwmA),
        .period    (periodA),
        .high_time (highA),
        .valid     (validA),
        .overflow  (overflowA)
    );

    pwm_capture #(.WORD_WIDTH(4)) dutB (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .clear     (clear),
        .pwm_in    (pwmB),
        .period    (periodB),
        .high_time (highB),
        .valid     (validB),
        .overflow  (overflowB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int hi, input int lo, input int n, input bit toB);
        for (int i = 0; i < n; i++) begin
            if (toB) pwmB = 1'b1; else pwmA = 1'b1;
            waitCycles(hi);
            if (toB) pwmB = 1'b0; else pwmA = 1'b0;
            waitCycles(lo);
        end
    endtask

    task automatic pushExpA(input int p, input int h, input int n);
        exp_t e;
        e.p = p;
        e.h = h;
        for (int i = 0; i < n; i++) qA.push_back(e);
    endtask

    task automatic clearDut();
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
    endtask

    // Monitors pop one expectation per valid pulse; a valid with nothing queued is an error.
    always @(negedge clk) begin
        exp_t e;
        if (validA) begin
            if (qA.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL spuriousValidA: got period %0d high %0d, expected no valid", periodA, highA);
            end else begin
                e = qA.pop_front();
                checkOutput("periodA", periodA, e.p);
                checkOutput("highTimeA", highA, e.h);
            end
            checkOutput("validPulseWidthA", {31'b0, prevValidA}, 32'd0);
        end
        prevValidA = validA;
    end

    always @(negedge clk) begin
        exp_t e;
        if (validB) begin
            if (qB.size() == 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL spuriousValidB: got period %0d high %0d, expected no valid", periodB, highB);
            end else begin
                e = qB.pop_front();
                checkOutput("periodB", {28'b0, periodB}, e.p);
                checkOutput("highTimeB", {28'b0, highB}, e.h);
            end
        end
        prevValidB = validB;
    end

    initial begin
        exp_t e;
        rstn   = 1'b0;
        enable = 1'b1;
        clear  = 1'b0;
        pwmA   = 1'b0;
        pwmB   = 1'b0;
        waitCycles(2);
        checkOutput("resetPeriodA", periodA, 32'd0);
        checkOutput("resetHighA", highA, 32'd0);
        checkOutput("resetValidA", {31'b0, validA}, 32'd0);
        checkOutput("resetOverflowA", {31'b0, overflowA}, 32'd0);
        checkOutput("resetOverflowB", {31'b0, overflowB}, 32'd0);
        rstn = 1'b1;
        waitCycles(3);

        // Four 3/5 periods: the first rise only arms, so three results follow.
        pushExpA(8, 3, 3);
        applyStimulus(3, 5, 4, 1'b0);
        waitCycles(6);
        checkOutput("basicDrainedA", qA.size(), 32'd0);
        checkOutput("basicOverflowA", {31'b0, overflowA}, 32'd0);
        checkOutput("basicHoldPeriodA", periodA, 32'd8);

        // Clear lands in the same cycle as the completing rise (two sync stages after pwm rises).
        pwmA = 1'b1;
        waitCycles(2);
        clear = 1'b1;
        waitCycles(1);
        clear = 1'b0;
        checkOutput("clearPeriodA", periodA, 32'd0);
        checkOutput("clearHighA", highA, 32'd0);
        checkOutput("clearValidA", {31'b0, validA}, 32'd0);
        waitCycles(1);
        pwmA = 1'b0;
        waitCycles(6);

        // Reset asserted mid-LOW after results 8/3.
        pushExpA(8, 3, 2);
        applyStimulus(3, 5, 3, 1'b0);
        waitCycles(2);
        checkOutput("preResetPeriodA", periodA, 32'd8);
        rstn = 1'b0;
        #1;
        checkOutput("asyncResetPeriodA", periodA, 32'd0);
        checkOutput("asyncResetHighA", highA, 32'd0);
        checkOutput("asyncResetValidA", {31'b0, validA}, 32'd0);
        checkOutput("asyncResetOverflowA", {31'b0, overflowA}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        waitCycles(2);
        pushExpA(8, 3, 1);
        applyStimulus(3, 5, 2, 1'b0);
        waitCycles(6);
        checkOutput("postResetDrainedA", qA.size(), 32'd0);

        // Enable dropped for 10 cycles mid-period, with a rise that must be ignored.
        clearDut();
        pushExpA(8, 3, 1);
        applyStimulus(3, 5, 2, 1'b0);
        enable = 1'b0;
        waitCycles(2);
        pwmA = 1'b1;
        waitCycles(3);
        pwmA = 1'b0;
        waitCycles(5);
        checkOutput("disabledPeriodA", periodA, 32'd8);
        checkOutput("disabledHighA", highA, 32'd3);
        checkOutput("disabledOverflowA", {31'b0, overflowA}, 32'd0);
        enable = 1'b1;
        waitCycles(3);
        pushExpA(8, 3, 1);
        applyStimulus(3, 5, 2, 1'b0);
        waitCycles(6);
        checkOutput("resumeDrainedA", qA.size(), 32'd0);

        // 4/12 waveform with a 2-cycle glitch four cycles into each low phase.
        clearDut();
        waitCycles(2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        pushExpA(16, 4, 2);
`else
        for (int i = 0; i < 2; i++) begin
            pushExpA(8, 4, 1);
            pushExpA(8, 2, 1);
        end
`endif
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4, 4, 1, 1'b0);
            applyStimulus(2, 6, 1, 1'b0);
        end
        applyStimulus(4, 12, 1, 1'b0);
        checkOutput("glitchDrainedA", qA.size(), 32'd0);

        // 4-bit instance: saturate in HIGH, then two rises 8 apart give one result.
        checkOutput("preSatOverflowB", {31'b0, overflowB}, 32'd0);
        pwmB = 1'b1;
        waitCycles(20);
        pwmB = 1'b0;
        waitCycles(5);
        checkOutput("satOverflowB", {31'b0, overflowB}, 32'd1);
        e.p = 32'd8;
        e.h = 32'd3;
        qB.push_back(e);
        applyStimulus(3, 5, 2, 1'b1);
        waitCycles(6);
        checkOutput("satDrainedB", qB.size(), 32'd0);
        checkOutput("stickyOverflowB", {31'b0, overflowB}, 32'd1);
        checkOutput("satPeriodB", {28'b0, periodB}, 32'd8);
        clearDut();
        checkOutput("clearOverflowB", {31'b0, overflowB}, 32'd0);
        checkOutput("finalDrainedA", qA.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
